// File: rtl/fpu_pkg.sv
// Shared FPU add-path widths and the stage payload carried between pipeline registers.
package fpu_pkg;

  localparam int FRAC_W    = 24;
  localparam int ALIGNED_W = 49;
  localparam int EXP_W     = 8;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W-1:0]     exponent;
    logic [ALIGNED_W-1:0] fraction;
  } adder_payload_t;

endpackage

// File: rtl/significand_lzc.sv
// Combinational leading-zero counter over the 2.47 significand, counted from the MSB.
module significand_lzc
  import fpu_pkg::*;
#(
  parameter int LZC_W = 6
) (
  input  logic [ALIGNED_W-1:0] value,
  output logic [LZC_W-1:0]     count,
  output logic                 zero
);

  // Scanning upward lets the highest set bit overwrite any lower one.
  always_comb begin
    count = LZC_W'(ALIGNED_W);
    for (int i = 0; i < ALIGNED_W; i++) begin
      if (value[i]) begin
        count = LZC_W'(ALIGNED_W - 1 - i);
      end
    end
  end

  assign zero = ~|value;

endmodule

// File: rtl/significand_adder.sv
// Two-stage significand add/subtract: S1 adds and corrects a borrow, S2 attaches the
// leading-zero count. Valid/ready handshake with full throughput.
module significand_adder
  import fpu_pkg::*;
#(
  parameter int LZC_W = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_is_sub,
  input  logic                 aligned_sign_a,
  input  logic [EXP_W-1:0]     aligned_exponent_a,
  input  logic [FRAC_W-1:0]    aligned_fraction_a,
  input  logic                 aligned_sign_b,
  input  logic [ALIGNED_W-1:0] aligned_fraction_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sum_sign,
  output logic [EXP_W-1:0]     sum_exponent,
  output logic [ALIGNED_W-1:0] sum_fraction,
  output logic [LZC_W-1:0]     sum_lzc,
  output logic                 sum_is_zero
);

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s1_load;
  logic                 s2_load;
  adder_payload_t       s1_d;
  adder_payload_t       s1_q;
  adder_payload_t       s2_q;
  logic [LZC_W-1:0]     s2_lzc;
  logic                 s2_zero;
  logic [LZC_W-1:0]     lzc_d;
  logic                 zero_d;

  logic                 eff_sub;
  logic [ALIGNED_W-1:0] a_ext;
  logic [ALIGNED_W:0]   raw;
  logic                 borrow;
  logic [ALIGNED_W-1:0] magnitude;

  assign s2_load  = out_ready | ~s2_valid;
  assign s1_load  = s2_load | ~s1_valid;
  assign in_ready = s1_load & ~flush;

  assign eff_sub   = aligned_sign_a ^ aligned_sign_b ^ op_is_sub;
  assign a_ext     = {1'b0, aligned_fraction_a, {FRAC_W{1'b0}}};
  assign raw       = eff_sub ? ({1'b0, a_ext} - {1'b0, aligned_fraction_b})
                             : ({1'b0, a_ext} + {1'b0, aligned_fraction_b});
  // A borrow only arises on equal exponents with b > a; negate back to a magnitude.
  assign borrow    = eff_sub & raw[ALIGNED_W];
  assign magnitude = borrow ? -raw[ALIGNED_W-1:0] : raw[ALIGNED_W-1:0];

  // An exact zero is always reported as +0.
  assign s1_d.sign     = (magnitude == '0) ? 1'b0 : (aligned_sign_a ^ borrow);
  assign s1_d.exponent = aligned_exponent_a;
  assign s1_d.fraction = magnitude;

  significand_lzc #(
    .LZC_W (LZC_W)
  ) u_lzc (
    .value (s1_q.fraction),
    .count (lzc_d),
    .zero  (zero_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      s2_lzc   <= '0;
      s2_zero  <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_q <= s1_d;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_q    <= s1_q;
          s2_lzc  <= lzc_d;
          s2_zero <= zero_d;
        end
      end
    end
  end

  assign out_valid    = s2_valid;
  assign sum_sign     = s2_q.sign;
  assign sum_exponent = s2_q.exponent;
  assign sum_fraction = s2_q.fraction;
  assign sum_lzc      = s2_lzc;
  assign sum_is_zero  = s2_zero;

endmodule
